// File: rtl/mult_accum.sv
// mult_accum: sums N unsigned 8-bit products into a 12-bit result.
//
// Handshake: start launches an accumulation. Terms are taken on
// product_valid && product_ready. After the N-th term the result is held
// on sum/sum_valid until sum_ready. If start and sum_ready arrive together
// in DONE, the next accumulation begins at once, with no idle cycle.
//
// Ports
//   clk           rising-edge clock
//   rst_n         async active-low reset
//   start         begin a new accumulation (IDLE, or DONE with sum_ready)
//   product[7:0]  unsigned term from the upstream multiplier
//   product_valid term present
//   product_ready block accepts a term (state ACC)
//   sum[11:0]     accumulator; meaningful while sum_valid
//   sum_valid     completed result held (state DONE)
//   sum_ready     downstream consumes sum
//   busy          state ACC or DONE
module mult_accum #(
    parameter int N = 4                  // terms per result, 1..16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [7:0]  product,
    input  logic        product_valid,
    output logic        product_ready,
    output logic [11:0] sum,
    output logic        sum_valid,
    input  logic        sum_ready,
    output logic        busy
);

    // The counter must be able to represent N itself.
    localparam int CW = $clog2(N + 1);

    typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;

    state_t         state, state_nx;
    logic [11:0]    acc;
    logic [CW-1:0]  cnt;
    logic           accept;
    logic           last;
    logic           clr;

    assign accept = (state == ACC) && product_valid;
    assign last   = accept && (cnt == CW'(N - 1));
    // Fresh accumulation from IDLE, or a back-to-back restart out of DONE.
    assign clr    = start && ((state == IDLE) || ((state == DONE) && sum_ready));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (start) state_nx = ACC;
            ACC:  if (last)  state_nx = DONE;
            DONE: if (sum_ready) state_nx = start ? ACC : IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // 16 * 255 = 4080 fits in 12 bits, so the sum never needs wrap handling.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
            cnt <= '0;
        end else if (clr) begin
            acc <= '0;
            cnt <= '0;
        end else if (accept) begin
            acc <= acc + {4'b0, product};
            cnt <= cnt + 1'b1;
        end
    end

    // The handshake outputs are decoded from state only, with no input paths.
    assign product_ready = (state == ACC);
    assign sum_valid     = (state == DONE);
    assign busy          = (state != IDLE);
    assign sum           = acc;

endmodule

// File: tb/tb_mult_accum.sv
module tb_mult_accum;

    logic clk = 1'b0;
    logic rst_n, start, product_valid, sum_ready;
    logic [7:0] product;
    logic [1:0]       pr, sv, bz;
    logic [1:0][11:0] sm;

    int cmp = 0;
    int bad = 0;

    always #5 clk = ~clk;

    // Instance 0 has N=4 and instance 1 has N=16. Both share the same stimulus.
    mult_accum #(.N(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(start), .product(product),
        .product_valid(product_valid), .product_ready(pr[0]), .sum(sm[0]),
        .sum_valid(sv[0]), .sum_ready(sum_ready), .busy(bz[0])
    );
    mult_accum #(.N(16)) dut16 (
        .clk(clk), .rst_n(rst_n), .start(start), .product(product),
        .product_valid(product_valid), .product_ready(pr[1]), .sum(sm[1]),
        .sum_valid(sv[1]), .sum_ready(sum_ready), .busy(bz[1])
    );

    // Reference model. phase: 0 waiting, 1 collecting, 2 holding result.
    int mph[2];
    int macc[2];
    int mcnt[2];

    function automatic int nterms(int k);
        return (k == 0) ? 4 : 16;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        for (int k = 0; k < 2; k++) begin
            if (!rst_n) begin
                mph[k] <= 0; macc[k] <= 0; mcnt[k] <= 0;
            end else begin
                case (mph[k])
                    0: if (start) begin
                        mph[k] <= 1; macc[k] <= 0; mcnt[k] <= 0;
                    end
                    1: if (product_valid) begin
                        macc[k] <= macc[k] + int'(product);
                        mcnt[k] <= mcnt[k] + 1;
                        if (mcnt[k] + 1 == nterms(k)) mph[k] <= 2;
                    end
                    default: if (sum_ready) begin
                        if (start) begin
                            mph[k] <= 1; macc[k] <= 0; mcnt[k] <= 0;
                        end else mph[k] <= 0;
                    end
                endcase
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        cmp++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d, want %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Check every cycle against the model.
    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("dut%0d product_ready", k), int'(pr[k]), int'(mph[k] == 1));
            chk($sformatf("dut%0d sum_valid", k),     int'(sv[k]), int'(mph[k] == 2));
            chk($sformatf("dut%0d busy", k),          int'(bz[k]), int'(mph[k] != 0));
            chk($sformatf("dut%0d sum", k),           int'(sm[k]), macc[k]);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic zeros(input string tag, input int k);
        chk({tag, " sum"},   int'(sm[k]), 0);
        chk({tag, " valid"}, int'(sv[k]), 0);
        chk({tag, " ready"}, int'(pr[k]), 0);
        chk({tag, " busy"},  int'(bz[k]), 0);
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; product_valid = 1'b0; product = '0; sum_ready = 1'b0;
        repeat (3) step();
        zeros("reset dut4", 0);
        zeros("reset dut16", 1);
        rst_n = 1'b1;
        step();

        // 4 x 225, then hold the result against stray product/start.
        start = 1'b1; step(); start = 1'b0;
        product_valid = 1'b1; product = 8'd225;
        repeat (4) step();
        product = 8'd7;
        @(negedge clk);
        chk("900 sum", int'(sm[0]), 900);
        chk("900 valid", int'(sv[0]), 1);
        chk("900 busy", int'(bz[0]), 1);
        repeat (5) step();
        @(negedge clk);
        chk("hold sum", int'(sm[0]), 900);
        chk("hold valid", int'(sv[0]), 1);
        chk("hold ready", int'(pr[0]), 0);
        sum_ready = 1'b1; step(); sum_ready = 1'b0; product_valid = 1'b0;
        @(negedge clk);
        chk("drain valid", int'(sv[0]), 0);
        chk("drain busy", int'(bz[0]), 0);
        chk("idle keeps sum", int'(sm[0]), 900);

        // Gapped beats 1..4.
        start = 1'b1; step(); start = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            product_valid = 1'b1; product = 8'(i); step();
            product_valid = 1'b0; repeat (2) step();
        end
        @(negedge clk);
        chk("gapped sum", int'(sm[0]), 10);
        chk("gapped valid", int'(sv[0]), 1);
        sum_ready = 1'b1; step(); sum_ready = 1'b0;

        // Reset in the middle of an accumulation.
        start = 1'b1; step(); start = 1'b0;
        product_valid = 1'b1; product = 8'd100;
        repeat (2) step();
        product_valid = 1'b0;
        rst_n = 1'b0; #1;
        zeros("midacc reset", 0);
        step(); rst_n = 1'b1; step();
        start = 1'b1; step(); start = 1'b0;
        product_valid = 1'b1; product = 8'd5;
        repeat (4) step();
        product_valid = 1'b0;
        @(negedge clk);
        chk("post-reset sum", int'(sm[0]), 20);
        chk("post-reset valid", int'(sv[0]), 1);

        // Back-to-back restart out of DONE.
        sum_ready = 1'b1; step(); sum_ready = 1'b0;
        start = 1'b1; step(); start = 1'b0;
        product_valid = 1'b1; product = 8'd225;
        repeat (4) step();
        product_valid = 1'b0;
        @(negedge clk);
        chk("b2b pre sum", int'(sm[0]), 900);
        start = 1'b1; sum_ready = 1'b1; step(); start = 1'b0; sum_ready = 1'b0;
        @(negedge clk);
        chk("b2b sum", int'(sm[0]), 0);
        chk("b2b ready", int'(pr[0]), 1);
        chk("b2b busy", int'(bz[0]), 1);
        chk("b2b valid", int'(sv[0]), 0);

        // Full-scale N=16: 16 x 255.
        rst_n = 1'b0; step(); rst_n = 1'b1; step();
        start = 1'b1; step(); start = 1'b0;
        product_valid = 1'b1; product = 8'd255;
        repeat (16) step();
        product_valid = 1'b0;
        @(negedge clk);
        chk("n16 sum", int'(sm[1]), 4080);
        chk("n16 valid", int'(sv[1]), 1);

        // Random traffic, including occasional resets.
        for (int c = 0; c < 1500; c++) begin
            start         = ($urandom % 4) == 0;
            product_valid = ($urandom % 3) != 0;
            product       = 8'($urandom);
            sum_ready     = ($urandom % 3) == 0;
            rst_n         = ($urandom % 97) != 0;
            step();
        end
        rst_n = 1'b1; start = 1'b0; product_valid = 1'b0; sum_ready = 1'b1;
        repeat (3) step();
        @(negedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, bad);
        $finish;
    end

endmodule
